// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter in front of a single-port RAM.
// Requests are latched at grant and sequenced through IDLE -> ACCESS -> DONE.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [1:0]        req0_cmd,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  input  logic [1:0]        req1_cmd,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy,
  output logic              grant,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_read,
  output logic              ram_write,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam int unsigned CNT_W = 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);
  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_RSVD  = 2'b10;
  localparam logic [1:0] CMD_READ  = 2'b11;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic              done0_d, done1_d, err_d, busy_d, grant_d;
  logic              ram_read_d, ram_write_d;
  logic [ADDR_W-1:0] ram_addr_d;
  logic [DATA_W-1:0] ram_din_d, rdata_d;
  logic              elig0, elig1, pick;

  assign elig0 = req0_valid && (req0_cmd != CMD_NONE);
  assign elig1 = req1_valid && (req1_cmd != CMD_NONE);

  // State and all outputs are registered; outputs are computed for the upcoming state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      cmd_q        <= CMD_NONE;
      addr_q       <= '0;
      done0        <= 1'b0;
      done1        <= 1'b0;
      err          <= 1'b0;
      busy         <= 1'b0;
      grant        <= 1'b0;
      rdata        <= '0;
      ram_addr     <= '0;
      ram_din      <= '0;
      ram_read     <= 1'b0;
      ram_write    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      cmd_q        <= cmd_d;
      addr_q       <= addr_d;
      done0        <= done0_d;
      done1        <= done1_d;
      err          <= err_d;
      busy         <= busy_d;
      grant        <= grant_d;
      rdata        <= rdata_d;
      ram_addr     <= ram_addr_d;
      ram_din      <= ram_din_d;
      ram_read     <= ram_read_d;
      ram_write    <= ram_write_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    cmd_d        = cmd_q;
    addr_d       = addr_q;
    grant_d      = grant;
    rdata_d      = rdata;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    err_d        = 1'b0;
    ram_addr_d   = '0;
    ram_din_d    = '0;
    ram_read_d   = 1'b0;
    ram_write_d  = 1'b0;
    pick         = 1'b0;

    case (state_q)
      IDLE: begin
        if (elig0 || elig1) begin
          // On a tie the port that did not win last time is served.
          pick        = (elig0 && elig1) ? ~last_grant_q : elig1;
          grant_d     = pick;
          cmd_d       = pick ? req1_cmd : req0_cmd;
          addr_d      = pick ? req1_addr : req0_addr;
          cnt_d       = '0;
          state_d     = ACCESS;
          ram_addr_d  = addr_d;
          ram_read_d  = (cmd_d == CMD_READ);
          ram_write_d = (cmd_d == CMD_WRITE);
          if (cmd_d == CMD_WRITE) begin
            ram_din_d = pick ? req1_wdata : req0_wdata;
          end
        end
      end
      ACCESS: begin
        if (cmd_q == CMD_READ && cnt_q != CNT_LAST) begin
          cnt_d      = cnt_q + 1'b1;
          ram_read_d = 1'b1;
          ram_addr_d = addr_q;
        end else begin
          state_d = DONE;
          done0_d = ~grant;
          done1_d = grant;
          err_d   = (cmd_q == CMD_RSVD);
          if (cmd_q == CMD_READ) begin
            rdata_d = ram_dout;
          end
        end
      end
      DONE: begin
        last_grant_d = grant;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: one instance with RD_LAT=1 (scoreboarded) and one with RD_LAT=3.
module tb_mem_bus_arbiter;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 16;

  typedef struct packed {
    logic              port;
    logic              err;
    logic              chk;
    logic [DATA_W-1:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  // Instance A: RD_LAT=1
  logic              req0_valid_a, req1_valid_a;
  logic [1:0]        req0_cmd_a, req1_cmd_a;
  logic [ADDR_W-1:0] req0_addr_a, req1_addr_a;
  logic [DATA_W-1:0] req0_wdata_a, req1_wdata_a;
  logic              done0_a, done1_a, err_a, busy_a, grant_a, ram_read_a, ram_write_a;
  logic [DATA_W-1:0] rdata_a, ram_din_a, ram_dout_a;
  logic [ADDR_W-1:0] ram_addr_a;
  logic [DATA_W-1:0] mem_a [2**ADDR_W];

  // Instance B: RD_LAT=3
  logic              req0_valid_b, req1_valid_b;
  logic [1:0]        req0_cmd_b, req1_cmd_b;
  logic [ADDR_W-1:0] req0_addr_b, req1_addr_b;
  logic [DATA_W-1:0] req0_wdata_b, req1_wdata_b;
  logic              done0_b, done1_b, err_b, busy_b, grant_b, ram_read_b, ram_write_b;
  logic [DATA_W-1:0] rdata_b, ram_din_b, ram_dout_b;
  logic [ADDR_W-1:0] ram_addr_b;
  logic [DATA_W-1:0] mem_b [2**ADDR_W];

  mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1)) u_dut_a (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid_a), .req0_cmd(req0_cmd_a), .req0_addr(req0_addr_a), .req0_wdata(req0_wdata_a),
    .req1_valid(req1_valid_a), .req1_cmd(req1_cmd_a), .req1_addr(req1_addr_a), .req1_wdata(req1_wdata_a),
    .done0(done0_a), .done1(done1_a), .rdata(rdata_a), .err(err_a), .busy(busy_a), .grant(grant_a),
    .ram_addr(ram_addr_a), .ram_din(ram_din_a), .ram_read(ram_read_a), .ram_write(ram_write_a),
    .ram_dout(ram_dout_a)
  );

  mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(3)) u_dut_b (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid_b), .req0_cmd(req0_cmd_b), .req0_addr(req0_addr_b), .req0_wdata(req0_wdata_b),
    .req1_valid(req1_valid_b), .req1_cmd(req1_cmd_b), .req1_addr(req1_addr_b), .req1_wdata(req1_wdata_b),
    .done0(done0_b), .done1(done1_b), .rdata(rdata_b), .err(err_b), .busy(busy_b), .grant(grant_b),
    .ram_addr(ram_addr_b), .ram_din(ram_din_b), .ram_read(ram_read_b), .ram_write(ram_write_b),
    .ram_dout(ram_dout_b)
  );

  // RAM models: synchronous write, read data follows the held address.
  always @(posedge clk) if (ram_write_a) mem_a[ram_addr_a] <= ram_din_a;
  always @(posedge clk) if (ram_write_b) mem_b[ram_addr_b] <= ram_din_b;
  assign ram_dout_a = mem_a[ram_addr_a];
  assign ram_dout_b = mem_b[ram_addr_b];

  // Scoreboard: every done pulse on instance A pops one expected completion.
  always @(negedge clk) begin
    if (!reset && (done0_a || done1_a)) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_done: done0=%0b done1=%0b, required no done", done0_a, done1_a);
      end else begin
        mon_e = sb_q.pop_front();
        if (done1_a !== mon_e.port || done0_a !== !mon_e.port || err_a !== mon_e.err ||
            grant_a !== mon_e.port || (mon_e.chk && rdata_a !== mon_e.rdata)) begin
          errors++;
          $display("FAIL sb_completion: done0=%0b done1=%0b err=%0b grant=%0b rdata=%h, required port=%0b err=%0b rdata=%h(chk=%0b)",
                   done0_a, done1_a, err_a, grant_a, rdata_a, mon_e.port, mon_e.err, mon_e.rdata, mon_e.chk);
        end
      end
    end
  end

  task automatic req_a(input int p, input logic v, input logic [1:0] c,
                       input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    if (p == 0) begin
      req0_valid_a = v; req0_cmd_a = c; req0_addr_a = a; req0_wdata_a = d;
    end else begin
      req1_valid_a = v; req1_cmd_a = c; req1_addr_a = a; req1_wdata_a = d;
    end
  endtask

  task automatic req_b(input int p, input logic v, input logic [1:0] c,
                       input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    if (p == 0) begin
      req0_valid_b = v; req0_cmd_b = c; req0_addr_b = a; req0_wdata_b = d;
    end else begin
      req1_valid_b = v; req1_cmd_b = c; req1_addr_b = a; req1_wdata_b = d;
    end
  endtask

  task automatic wait_done_a(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done0_a || done1_a) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({done0_a, done1_a, err_a, busy_a, grant_a, ram_read_a, ram_write_a, ram_addr_a, ram_din_a, rdata_a} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_a: done0=%0b done1=%0b err=%0b busy=%0b grant=%0b rd=%0b wr=%0b addr=%h din=%h rdata=%h, required all 0",
               done0_a, done1_a, err_a, busy_a, grant_a, ram_read_a, ram_write_a, ram_addr_a, ram_din_a, rdata_a);
    end
    checks++;
    if ({busy_b, grant_b, ram_read_b, ram_write_b, rdata_b} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_b: busy=%0b grant=%0b rd=%0b wr=%0b rdata=%h, required all 0",
               busy_b, grant_b, ram_read_b, ram_write_b, rdata_b);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%0b, required 0", busy_a);
    end
  endtask

  task automatic test_write;
    int cyc;
    req_a(0, 1'b1, 2'b01, 9'h005, 16'hABCD);
    sb_q.push_back('{port: 1'b0, err: 1'b0, chk: 1'b0, rdata: '0});
    @(negedge clk);
    checks++;
    if ({ram_write_a, ram_read_a, busy_a, grant_a, done0_a} !== 5'b10100 || ram_addr_a !== 9'h005 || ram_din_a !== 16'hABCD) begin
      errors++;
      $display("FAIL write_access: wr=%0b rd=%0b busy=%0b grant=%0b done0=%0b addr=%h din=%h, required wr=1 rd=0 busy=1 grant=0 done0=0 addr=005 din=abcd",
               ram_write_a, ram_read_a, busy_a, grant_a, done0_a, ram_addr_a, ram_din_a);
    end
    @(negedge clk);
    checks++;
    if ({done0_a, done1_a, err_a, ram_write_a, ram_addr_a, ram_din_a} !== {4'b1000, 9'h0, 16'h0}) begin
      errors++;
      $display("FAIL write_done: done0=%0b done1=%0b err=%0b wr=%0b addr=%h din=%h, required 1 0 0 0 0 0",
               done0_a, done1_a, err_a, ram_write_a, ram_addr_a, ram_din_a);
    end
    req_a(0, 1'b0, 2'b00, '0, '0);
    @(negedge clk);
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("FAIL write_idle_after: busy=%0b, required 0", busy_a);
    end
    req_a(1, 1'b1, 2'b01, 9'h006, 16'h1234);
    sb_q.push_back('{port: 1'b1, err: 1'b0, chk: 1'b0, rdata: '0});
    wait_done_a(cyc);
    checks++;
    if (cyc != 2) begin
      errors++;
      $display("FAIL write_port1_latency: cycle=%0d, required 2", cyc);
    end
    req_a(1, 1'b0, 2'b00, '0, '0);
    @(negedge clk);
  endtask

  task automatic test_read;
    req_a(1, 1'b1, 2'b11, 9'h005, '0);
    sb_q.push_back('{port: 1'b1, err: 1'b0, chk: 1'b1, rdata: 16'hABCD});
    @(negedge clk);
    checks++;
    if ({ram_read_a, ram_write_a, done1_a} !== 3'b100 || ram_addr_a !== 9'h005 || ram_din_a !== 16'h0) begin
      errors++;
      $display("FAIL read_access: rd=%0b wr=%0b done1=%0b addr=%h din=%h, required rd=1 wr=0 done1=0 addr=005 din=0",
               ram_read_a, ram_write_a, done1_a, ram_addr_a, ram_din_a);
    end
    @(negedge clk);
    checks++;
    if ({done1_a, done0_a, ram_read_a, grant_a} !== 4'b1001 || rdata_a !== 16'hABCD) begin
      errors++;
      $display("FAIL read_done: done1=%0b done0=%0b rd=%0b grant=%0b rdata=%h, required 1 0 0 1 abcd",
               done1_a, done0_a, ram_read_a, grant_a, rdata_a);
    end
    req_a(1, 1'b0, 2'b00, '0, '0);
    @(negedge clk);
  endtask

  task automatic test_reserved;
    logic en_seen;
    en_seen = 1'b0;
    req_a(0, 1'b1, 2'b10, 9'h003, 16'h7777);
    sb_q.push_back('{port: 1'b0, err: 1'b1, chk: 1'b1, rdata: 16'hABCD});
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      en_seen = en_seen | ram_read_a | ram_write_a;
    end
    checks++;
    if ({done0_a, err_a, en_seen} !== 3'b110 || rdata_a !== 16'hABCD) begin
      errors++;
      $display("FAIL reserved_cmd: done0=%0b err=%0b ram_en_seen=%0b rdata=%h, required 1 1 0 abcd",
               done0_a, err_a, en_seen, rdata_a);
    end
    req_a(0, 1'b0, 2'b00, '0, '0);
    @(negedge clk);
    checks++;
    if (err_a !== 1'b0) begin
      errors++;
      $display("FAIL reserved_err_pulse: err=%0b, required 0 after done", err_a);
    end
  endtask

  task automatic test_round_robin;
    int cyc;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req_a(0, 1'b1, 2'b11, 9'h005, '0);
    req_a(1, 1'b1, 2'b11, 9'h006, '0);
    for (int k = 0; k < 6; k++) begin
      sb_q.push_back('{port: k[0], err: 1'b0, chk: 1'b1, rdata: k[0] ? 16'h1234 : 16'hABCD});
    end
    for (int k = 0; k < 6; k++) begin
      wait_done_a(cyc);
      checks++;
      if (cyc != ((k == 0) ? 2 : 3) || grant_a !== k[0]) begin
        errors++;
        $display("FAIL round_robin_%0d: cycles=%0d grant=%0b, required cycles=%0d grant=%0b",
                 k, cyc, grant_a, (k == 0) ? 2 : 3, k[0]);
      end
      if (cyc == 0) break;
    end
    req_a(0, 1'b0, 2'b00, '0, '0);
    req_a(1, 1'b0, 2'b00, '0, '0);
    @(negedge clk);
  endtask

  task automatic test_hold_and_ignore;
    int busy_cnt;
    req_a(0, 1'b1, 2'b11, 9'h006, '0);
    sb_q.push_back('{port: 1'b0, err: 1'b0, chk: 1'b1, rdata: 16'h1234});
    @(negedge clk);
    checks++;
    if (ram_read_a !== 1'b1 || ram_addr_a !== 9'h006) begin
      errors++;
      $display("FAIL hold_access: rd=%0b addr=%h, required 1 006", ram_read_a, ram_addr_a);
    end
    req_a(0, 1'b0, 2'b00, 9'h005, '0);
    @(negedge clk);
    checks++;
    if (done0_a !== 1'b1 || rdata_a !== 16'h1234) begin
      errors++;
      $display("FAIL hold_done: done0=%0b rdata=%h, required 1 1234", done0_a, rdata_a);
    end
    req_a(0, 1'b1, 2'b00, 9'h005, 16'h5555);
    busy_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      busy_cnt += int'(busy_a) + int'(ram_read_a) + int'(ram_write_a);
    end
    checks++;
    if (busy_cnt != 0) begin
      errors++;
      $display("FAIL cmd00_ignored: busy/ram activity cycles=%0d, required 0", busy_cnt);
    end
    req_a(0, 1'b0, 2'b00, '0, '0);
  endtask

  task automatic test_read_latency3;
    int cyc;
    int nread;
    logic addr_bad;
    req_b(0, 1'b1, 2'b01, 9'h005, 16'h5A5A);
    cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done0_b) begin cyc = i; break; end
    end
    checks++;
    if (cyc != 2) begin
      errors++;
      $display("FAIL b_write_latency: cycle=%0d, required 2", cyc);
    end
    req_b(0, 1'b0, 2'b00, '0, '0);
    @(negedge clk);
    req_b(1, 1'b1, 2'b11, 9'h005, '0);
    cyc = 0;
    nread = 0;
    addr_bad = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ram_read_b) begin
        nread++;
        if (ram_addr_b !== 9'h005) addr_bad = 1'b1;
      end
      if (i == 1) req_b(1, 1'b0, 2'b00, 9'h1FF, '0);
      if (done1_b) begin cyc = i; break; end
    end
    checks++;
    if (cyc != 4 || nread != 3 || addr_bad || rdata_b !== 16'h5A5A || grant_b !== 1'b1 || done0_b !== 1'b0) begin
      errors++;
      $display("FAIL b_read_lat3: done_cycle=%0d read_cycles=%0d addr_bad=%0b rdata=%h grant=%0b done0=%0b, required 4 3 0 5a5a 1 0",
               cyc, nread, addr_bad, rdata_b, grant_b, done0_b);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_read;
    int cyc;
    int ndone;
    req_b(1, 1'b1, 2'b11, 9'h005, '0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (ram_read_b !== 1'b1 || grant_b !== 1'b1 || busy_b !== 1'b1) begin
      errors++;
      $display("FAIL midread_pre: rd=%0b grant=%0b busy=%0b, required 1 1 1", ram_read_b, grant_b, busy_b);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy_b, ram_read_b, grant_b, done1_b} !== 4'b0000 || ram_addr_b !== 9'h0) begin
      errors++;
      $display("FAIL midread_async_reset: busy=%0b rd=%0b grant=%0b done1=%0b addr=%h, required all 0",
               busy_b, ram_read_b, grant_b, done1_b, ram_addr_b);
    end
    req_b(1, 1'b0, 2'b00, '0, '0);
    ndone = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      ndone += int'(done0_b) + int'(done1_b);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ndone += int'(done0_b) + int'(done1_b) + int'(busy_b);
    end
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("FAIL midread_no_done: done/busy cycles=%0d, required 0", ndone);
    end
    req_b(1, 1'b1, 2'b11, 9'h005, '0);
    cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done1_b) begin cyc = i; break; end
    end
    checks++;
    if (cyc != 4 || grant_b !== 1'b1 || rdata_b !== 16'h5A5A) begin
      errors++;
      $display("FAIL after_reset_port1: done_cycle=%0d grant=%0b rdata=%h, required 4 1 5a5a", cyc, grant_b, rdata_b);
    end
    req_b(1, 1'b0, 2'b00, '0, '0);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    req_a(0, 1'b0, 2'b00, '0, '0);
    req_a(1, 1'b0, 2'b00, '0, '0);
    req_b(0, 1'b0, 2'b00, '0, '0);
    req_b(1, 1'b0, 2'b00, '0, '0);
    repeat (2) @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_reserved();
    test_round_robin();
    test_hold_and_ignore();
    test_read_latency3();
    test_reset_mid_read();
    repeat (2) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: pending=%0d, required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
